// File: rtl/note_recorder_pkg.sv
// Shared note codes and FSM state encodings for the note recorder.
// Note codes match the keyboard decoder and tone generator mux.
package note_recorder_pkg;

   localparam int NOTE_W = 4;

   localparam logic [NOTE_W-1:0] NOTE_NONE = 4'd0;
   localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
   localparam logic [NOTE_W-1:0] NOTE_D    = 4'd2;
   localparam logic [NOTE_W-1:0] NOTE_E    = 4'd3;
   localparam logic [NOTE_W-1:0] NOTE_F    = 4'd4;
   localparam logic [NOTE_W-1:0] NOTE_G    = 4'd5;
   localparam logic [NOTE_W-1:0] NOTE_A    = 4'd6;
   localparam logic [NOTE_W-1:0] NOTE_B    = 4'd7;
   localparam logic [NOTE_W-1:0] NOTE_C5   = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RECORD = 2'd1,
      ST_PLAY   = 2'd2
   } state_t;

endpackage

// File: rtl/note_recorder_ram_sp.sv
// note_ram_sp: DEPTH x W single-port RAM, synchronous write, registered read.
// Ports: clk, we, addr, wdata in; rdata out (mem[addr] one edge later).
module note_ram_sp #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6,
   parameter int W      = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [W-1:0]      wdata,
   output logic [W-1:0]      rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/note_recorder.sv
// note_recorder: records live_note once per BEAT_TICK, replays it on play_note.
// Ports: CLK, RESET_N, BEAT_TICK, REC_START, PLAY_START, STOP, live_note in;
//   play_note, rec_len, recording, playing, full out.
// Option: NOTE_RECORDER_LOOP_EN makes playback loop until STOP/REC_START.
module note_recorder
   import note_recorder_pkg::*;
#(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              BEAT_TICK,
   input  logic              REC_START,
   input  logic              PLAY_START,
   input  logic              STOP,
   input  logic [NOTE_W-1:0] live_note,
   output logic [NOTE_W-1:0] play_note,
   output logic [ADDR_W:0]   rec_len,
   output logic              recording,
   output logic              playing,
   output logic              full
);

   localparam int LEN_W = ADDR_W + 1;
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(DEPTH);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_t state_q;
   state_t state_d;

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] ram_addr;
   logic [LEN_W-1:0]  len_q;
   logic [NOTE_W-1:0] ram_rdata;

   logic cmd;
   logic tick;
   logic rec_clr;
   logic wr_en;
   logic rd_en;
   logic rd_rst;
   logic rd_last;
   logic rd_pend;
`ifndef NOTE_RECORDER_LOOP_EN
   logic end_hold;
`endif

   // Any command pulse swallows a coincident tick.
   assign cmd     = STOP | REC_START | PLAY_START;
   assign tick    = BEAT_TICK & ~cmd;
   assign rd_last = ({1'b0, rd_ptr} == (len_q - LEN_ONE));

   // Record and play never overlap, so one port is shared.
   assign ram_addr = (state_q == ST_RECORD) ? wr_ptr : rd_ptr;

   note_ram_sp #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .W      (NOTE_W)
   ) u_ram (
      .clk   (CLK),
      .we    (wr_en),
      .addr  (ram_addr),
      .wdata (live_note),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_d = state_q;
      rec_clr = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      rd_rst  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (STOP) begin
               state_d = ST_IDLE;
            end else if (REC_START) begin
               state_d = ST_RECORD;
               rec_clr = 1'b1;
            end else if (PLAY_START && len_q != '0) begin
               state_d = ST_PLAY;
               rd_rst  = 1'b1;
            end
         end
         ST_RECORD: begin
            if (STOP) begin
               state_d = ST_IDLE;
            end else if (REC_START) begin
               rec_clr = 1'b1;
            end else if (tick) begin
               wr_en = 1'b1;
               // The write filling the last slot ends the take.
               if (len_q >= LEN_MAX - LEN_ONE) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_PLAY: begin
            if (STOP) begin
               state_d = ST_IDLE;
            end else if (REC_START) begin
               state_d = ST_RECORD;
               rec_clr = 1'b1;
            end else if (tick) begin
`ifdef NOTE_RECORDER_LOOP_EN
               rd_en = 1'b1;
`else
               // Last note was held for a full beat; now stop.
               if (end_hold) begin
                  state_d = ST_IDLE;
               end else begin
                  rd_en = 1'b1;
               end
`endif
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= ST_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         len_q     <= '0;
         rd_pend   <= 1'b0;
         play_note <= NOTE_NONE;
`ifndef NOTE_RECORDER_LOOP_EN
         end_hold  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;

         if (rec_clr) begin
            wr_ptr <= '0;
            len_q  <= '0;
         end else if (wr_en) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (len_q != LEN_MAX) begin
               len_q <= len_q + LEN_ONE;
            end
         end

         if (rd_rst) begin
            rd_ptr <= '0;
         end else if (rd_en) begin
`ifdef NOTE_RECORDER_LOOP_EN
            rd_ptr <= rd_last ? '0 : rd_ptr + ADDR_W'(1);
`else
            rd_ptr <= rd_ptr + ADDR_W'(1);
`endif
         end

`ifndef NOTE_RECORDER_LOOP_EN
         if (rd_rst) begin
            end_hold <= 1'b0;
         end else if (rd_en) begin
            end_hold <= rd_last;
         end
`endif

         // RAM read is registered: note lands one edge after the tick.
         rd_pend <= rd_en;
         if (state_d != ST_PLAY) begin
            play_note <= NOTE_NONE;
         end else if (rd_pend) begin
            play_note <= ram_rdata;
         end
      end
   end

   assign rec_len   = len_q;
   assign recording = (state_q == ST_RECORD);
   assign playing   = (state_q == ST_PLAY);
   assign full      = (len_q == LEN_MAX);

endmodule

// File: tb/tb_note_recorder.sv
// Directed self-checking bench for note_recorder.
// Loop-mode expectations follow NOTE_RECORDER_LOOP_EN.
module tb_note_recorder;
   import note_recorder_pkg::*;

   logic              CLK;
   logic              RESET_N;
   logic              BEAT_TICK;
   logic              REC_START;
   logic              PLAY_START;
   logic              STOP;
   logic [NOTE_W-1:0] live_note;
   logic [NOTE_W-1:0] play_note;
   logic [6:0]        rec_len;
   logic              recording;
   logic              playing;
   logic              full;

   int checks;
   int failures;

   note_recorder dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .BEAT_TICK  (BEAT_TICK),
      .REC_START  (REC_START),
      .PLAY_START (PLAY_START),
      .STOP       (STOP),
      .live_note  (live_note),
      .play_note  (play_note),
      .rec_len    (rec_len),
      .recording  (recording),
      .playing    (playing),
      .full       (full)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   // Entered at a negedge; inputs are sampled on the next posedge,
   // and the task returns at the following negedge.
   task automatic step(input logic t, input logic r, input logic p,
                       input logic s, input logic [NOTE_W-1:0] n);
      BEAT_TICK  = t;
      REC_START  = r;
      PLAY_START = p;
      STOP       = s;
      live_note  = n;
      @(negedge CLK);
      BEAT_TICK  = 1'b0;
      REC_START  = 1'b0;
      PLAY_START = 1'b0;
      STOP       = 1'b0;
      live_note  = NOTE_NONE;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 1'b0, NOTE_NONE);
   endtask

   task automatic tick_note(input logic [NOTE_W-1:0] n);
      step(1'b1, 1'b0, 1'b0, 1'b0, n);
   endtask

   // One replay tick, then the cycle in which the note appears.
   task automatic play_check(input string tag, input logic [NOTE_W-1:0] exp);
      tick_note(NOTE_NONE);
      idle();
      check(tag, int'(play_note), int'(exp));
   endtask

   logic [NOTE_W-1:0] eefg [4];
   logic [NOTE_W-1:0] abc  [3];

   initial begin
      checks     = 0;
      failures   = 0;
      RESET_N    = 1'b0;
      BEAT_TICK  = 1'b0;
      REC_START  = 1'b0;
      PLAY_START = 1'b0;
      STOP       = 1'b0;
      live_note  = NOTE_NONE;
      eefg[0] = NOTE_E; eefg[1] = NOTE_E; eefg[2] = NOTE_F; eefg[3] = NOTE_G;
      abc[0]  = NOTE_A; abc[1]  = NOTE_B; abc[2]  = NOTE_C5;

      repeat (3) @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);

      check("rst_play_note", int'(play_note), int'(NOTE_NONE));
      check("rst_rec_len", int'(rec_len), 0);
      check("rst_recording", int'(recording), 0);
      check("rst_playing", int'(playing), 0);
      check("rst_full", int'(full), 0);

      // PLAY_START with empty buffer is ignored
      step(1'b0, 1'b0, 1'b1, 1'b0, NOTE_NONE);
      check("empty_play_playing", int'(playing), 0);
      tick_note(NOTE_NONE);
      idle();
      check("empty_play_note", int'(play_note), int'(NOTE_NONE));

      // Record E,E,F,G then replay
      step(1'b0, 1'b1, 1'b0, 1'b0, NOTE_NONE);
      check("rec1_recording", int'(recording), 1);
      for (int i = 0; i < 4; i++) tick_note(eefg[i]);
      step(1'b0, 1'b0, 1'b0, 1'b1, NOTE_NONE);
      check("rec1_len", int'(rec_len), 4);
      check("rec1_stopped", int'(recording), 0);
      step(1'b0, 1'b0, 1'b1, 1'b0, NOTE_NONE);
      check("play1_playing", int'(playing), 1);
      tick_note(NOTE_NONE);
      check("play1_latency", int'(play_note), int'(NOTE_NONE));
      idle();
      check("play1_n0", int'(play_note), int'(eefg[0]));
      idle();
      check("play1_hold", int'(play_note), int'(eefg[0]));
      for (int i = 1; i < 4; i++) play_check($sformatf("play1_n%0d", i), eefg[i]);
`ifndef NOTE_RECORDER_LOOP_EN
      tick_note(NOTE_NONE);
      check("play1_end_note", int'(play_note), int'(NOTE_NONE));
      check("play1_end_idle", int'(playing), 0);
`else
      step(1'b0, 1'b0, 1'b0, 1'b1, NOTE_NONE);
      check("play1_stop_note", int'(play_note), int'(NOTE_NONE));
      check("play1_stop_idle", int'(playing), 0);
`endif

      // STOP beats PLAY_START while recording
      step(1'b0, 1'b1, 1'b0, 1'b0, NOTE_NONE);
      tick_note(NOTE_C4);
      step(1'b0, 1'b0, 1'b1, 1'b1, NOTE_NONE);
      check("stopplay_recording", int'(recording), 0);
      check("stopplay_playing", int'(playing), 0);
      check("stopplay_len", int'(rec_len), 1);
      tick_note(NOTE_NONE);
      idle();
      check("stopplay_note", int'(play_note), int'(NOTE_NONE));

      // Tick coincident with REC_START is dropped
      step(1'b1, 1'b1, 1'b0, 1'b0, NOTE_G);
      check("coinc_len", int'(rec_len), 0);
      check("coinc_recording", int'(recording), 1);
      for (int i = 0; i < 3; i++) tick_note(abc[i]);
      check("abc_len", int'(rec_len), 3);
      step(1'b0, 1'b0, 1'b0, 1'b1, NOTE_NONE);
      step(1'b0, 1'b0, 1'b1, 1'b0, NOTE_NONE);
`ifdef NOTE_RECORDER_LOOP_EN
      for (int i = 0; i < 7; i++) play_check($sformatf("loop_n%0d", i), abc[i % 3]);
      check("loop_playing", int'(playing), 1);
      step(1'b0, 1'b0, 1'b0, 1'b1, NOTE_NONE);
      check("loop_stop", int'(playing), 0);
`else
      for (int i = 0; i < 3; i++) play_check($sformatf("abc_n%0d", i), abc[i]);
      play_check("abc_end_note", NOTE_NONE);
      check("abc_end_idle", int'(playing), 0);
`endif

      // Fill all 64 slots with alternating C4/D
      step(1'b0, 1'b1, 1'b0, 1'b0, NOTE_NONE);
      for (int i = 0; i < 63; i++) tick_note((i % 2 == 0) ? NOTE_C4 : NOTE_D);
      check("fill63_len", int'(rec_len), 63);
      check("fill63_full", int'(full), 0);
      check("fill63_recording", int'(recording), 1);
      tick_note(NOTE_D);
      check("fill64_len", int'(rec_len), 64);
      check("fill64_full", int'(full), 1);
      check("fill64_idle", int'(recording), 0);
      tick_note(NOTE_C4);
      check("fill65_len", int'(rec_len), 64);

      step(1'b0, 1'b0, 1'b1, 1'b0, NOTE_NONE);
      play_check("full_n0", NOTE_C4);
      play_check("full_n1", NOTE_D);
      play_check("full_n2", NOTE_C4);

      // Asynchronous reset mid-play
      #2;
      RESET_N = 1'b0;
      #1;
      check("arst_note", int'(play_note), int'(NOTE_NONE));
      check("arst_len", int'(rec_len), 0);
      check("arst_playing", int'(playing), 0);
      check("arst_full", int'(full), 0);
      @(negedge CLK);
      RESET_N = 1'b1;
      @(negedge CLK);
      step(1'b0, 1'b0, 1'b1, 1'b0, NOTE_NONE);
      check("arst_noplay", int'(playing), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
